psdsqrt_sched: RTL and testbench

- Round-robin scheduler that shares one psdsqrt square-root datapath among NREQ requesters.
- Arbitrates requests and drives the datapath's start/stop pulses and operand.
- Counts the NBITSIN/2 iteration cycles, captures the result and returns it to the winning requester with a done pulse.
- Sits between requester blocks and a single psdsqrt instance.

---
 rtl/psdsqrt_sched.sv | 145 ++++++++++++++
 tb/tb_psdsqrt_sched.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/psdsqrt_sched.sv
// psdsqrt_sched: round-robin scheduler sharing one psdsqrt square-root
// datapath among NREQ requesters.
//
// Ports:
//   clock     rising-edge master clock
//   reset     asynchronous active-low reset
//   req       per-requester request, held until the matching ack
//   xin_all   packed operands, requester i at [i*NBITSIN +: NBITSIN]
//   ack       one-hot pulse, operand of the granted requester consumed
//   done      one-hot pulse, sqrt_out valid for the granted requester
//   sqrt_out  result, 0 unless done is non-zero
//   busy      high whenever a job is in flight
//   sq_start  datapath start pulse
//   sq_stop   datapath stop pulse
//   sq_xin    datapath operand, 0 outside START
//   sq_sqrt   registered result from the datapath
//
// A job walks IDLE -> START -> RUN (NBITSIN/2 cycles) -> STOP -> WAIT -> DONE.
// DONE re-arbitrates directly, so back-to-back jobs skip IDLE.

module psdsqrt_sched #(
    parameter int NBITSIN = 32,
    parameter int NREQ    = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*NBITSIN-1:0]   xin_all,
    output logic [NREQ-1:0]           ack,
    output logic [NREQ-1:0]           done,
    output logic [NBITSIN/2-1:0]      sqrt_out,
    output logic                      busy,
    output logic                      sq_start,
    output logic                      sq_stop,
    output logic [NBITSIN-1:0]        sq_xin,
    input  logic [NBITSIN/2-1:0]      sq_sqrt
);

    localparam int HW = NBITSIN / 2;
    localparam int CW = $clog2(HW) + 1;
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(HW - 1);
    localparam logic [GW-1:0] LAST_INIT = GW'(NREQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_STOP,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [GW-1:0]   gnt, last_gnt;
    logic [GW-1:0]   win, cand;
    logic            any_req;
    logic            gnt_ld;

    // Round-robin pick: scan from the slot after the last winner, wrapping,
    // and take the first requester that is high.
    always_comb begin
        win     = last_gnt;
        cand    = '0;
        any_req = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = GW'((int'(last_gnt) + k) % NREQ);
            if (!any_req && req[cand]) begin
                win     = cand;
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        gnt_ld   = 1'b0;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_nx = S_START;
                    gnt_ld   = 1'b1;
                end
            end
            S_START: begin
                state_nx = S_RUN;
                cnt_nx   = '0;
            end
            S_RUN: begin
                cnt_nx = cnt + 1'b1;
                if (cnt == CNT_LAST) state_nx = S_STOP;
            end
            S_STOP:  state_nx = S_WAIT;
            S_WAIT:  state_nx = S_DONE;
            S_DONE: begin
                if (any_req) begin
                    state_nx = S_START;
                    gnt_ld   = 1'b1;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            gnt      <= '0;
            last_gnt <= LAST_INIT;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (gnt_ld) begin
                gnt      <= win;
                last_gnt <= win;
            end
        end
    end

    // Outputs decode straight from state so an asynchronous reset clears
    // them in the same instant.
    always_comb begin
        ack      = '0;
        done     = '0;
        sqrt_out = '0;
        sq_xin   = '0;
        busy     = (state != S_IDLE);
        sq_start = (state == S_START);
        sq_stop  = (state == S_STOP);
        if (state == S_START) begin
            ack[gnt] = 1'b1;
            sq_xin   = xin_all[gnt*NBITSIN +: NBITSIN];
        end
        if (state == S_DONE) begin
            done[gnt] = 1'b1;
            sqrt_out  = sq_sqrt;
        end
    end

endmodule

// File: tb/tb_psdsqrt_sched.sv
module tb_psdsqrt_sched;

    localparam int NB  = 32;
    localparam int NR  = 4;
    localparam int HW  = NB / 2;
    localparam int LAT = HW + 4;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [NR-1:0]    req = '0;
    logic [NR*NB-1:0] xin_all = '0;
    logic [NR-1:0]    ack, done;
    logic [HW-1:0]    sqrt_out;
    logic             busy, sq_start, sq_stop;
    logic [NB-1:0]    sq_xin;
    logic [HW-1:0]    sq_sqrt = '0;

    psdsqrt_sched #(.NBITSIN(NB), .NREQ(NR)) dut (
        .clock(clock), .reset(reset), .req(req), .xin_all(xin_all),
        .ack(ack), .done(done), .sqrt_out(sqrt_out), .busy(busy),
        .sq_start(sq_start), .sq_stop(sq_stop), .sq_xin(sq_xin),
        .sq_sqrt(sq_sqrt)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic longint isqrt(input longint x);
        longint r = 0;
        for (int b = HW - 1; b >= 0; b--)
            if ((r + (longint'(1) << b)) * (r + (longint'(1) << b)) <= x)
                r += (longint'(1) << b);
        return r;
    endfunction

    function automatic int oh(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Stand-in for the psdsqrt datapath: latch operand on start, load the
    // registered result on the stop edge.
    logic [NB-1:0] dp_x = '0;
    always @(posedge clock) begin
        if (sq_start) dp_x <= sq_xin;
        if (sq_stop)  sq_sqrt <= HW'(isqrt(longint'(dp_x)));
    end

    // Transaction-level reference: a job arbitrated at cycle a acks at a+1,
    // stops at a+HW+2, completes at a+LAT; the next pick happens at a+LAT.
    int            next_arb = 0, job_a = -1, job_g = 0, last = NR - 1, w = 0;
    logic [NB-1:0] job_op = '0;
    logic [NR-1:0] e_ack, e_done, got_ack = '0;
    logic [HW-1:0] e_sq;
    logic [NB-1:0] e_x;
    logic          e_busy, e_st, e_sp;
    int ack_g[$], ack_c[$], done_g[$], done_v[$], done_c[$];
    int start_c = -1, stop_c = -1, act = 0;

    always @(negedge clock) begin
        e_ack = '0; e_done = '0; e_sq = '0; e_x = '0;
        e_busy = 1'b0; e_st = 1'b0; e_sp = 1'b0;
        if (!reset) begin
            job_a = -1; last = NR - 1; next_arb = cyc + 1;
        end else if (job_a >= 0) begin
            e_busy = (cyc > job_a) && (cyc <= job_a + LAT);
            if (cyc == job_a + 1) begin
                e_st = 1'b1; e_ack[job_g] = 1'b1; e_x = job_op;
            end
            if (cyc == job_a + HW + 2) e_sp = 1'b1;
            if (cyc == job_a + LAT) begin
                e_done[job_g] = 1'b1; e_sq = HW'(isqrt(longint'(job_op)));
            end
        end
        chk("ack", ack, e_ack);
        chk("done", done, e_done);
        chk("sqrt_out", sqrt_out, e_sq);
        chk("busy", busy, e_busy);
        chk("sq_start", sq_start, e_st);
        chk("sq_stop", sq_stop, e_sp);
        chk("sq_xin", sq_xin, e_x);
        if (ack != 0) begin
            got_ack |= ack; ack_g.push_back(oh(ack)); ack_c.push_back(cyc);
        end
        if (done != 0) begin
            done_g.push_back(oh(done)); done_v.push_back(int'(sqrt_out)); done_c.push_back(cyc);
        end
        if (sq_start) start_c = cyc;
        if (sq_stop)  stop_c  = cyc;
        if (busy || sq_start || sq_stop || ack != 0 || done != 0) act++;
        if (reset && cyc >= next_arb) begin
            if (req != 0) begin
                w = -1;
                for (int k = 1; k <= NR; k++)
                    if (w < 0 && req[(last + k) % NR]) w = (last + k) % NR;
                job_a = cyc; job_g = w; job_op = xin_all[w*NB +: NB];
                last = w; next_arb = cyc + LAT;
            end else begin
                next_arb = cyc + 1;
            end
        end
    end

    function automatic logic [NB-1:0] rnd_op();
        if ($urandom_range(0, 3) == 0) return NB'($urandom_range(0, 300));
        return $urandom;
    endfunction

    // Requester behaviour: drop req after ack unless rereq says to
    // re-request with a fresh operand; optionally raise random requests.
    task automatic drive(input int n, input logic [NR-1:0] rereq, input bit rnd);
        for (int c = 0; c < n; c++) begin
            @(posedge clock); #1;
            for (int i = 0; i < NR; i++) begin
                if (got_ack[i]) begin
                    got_ack[i] = 1'b0;
                    if (rereq[i]) xin_all[i*NB +: NB] = rnd_op();
                    else req[i] = 1'b0;
                end else if (rnd && !req[i] && $urandom_range(0, 7) == 0) begin
                    xin_all[i*NB +: NB] = rnd_op();
                    req[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic job(input int i, input logic [NB-1:0] op,
                       output logic [HW-1:0] res, output int t_ack, output int t_done);
        int t0;
        bit ok;
        res = '0;
        @(posedge clock); #1;
        t0 = cyc; req[i] = 1'b1; xin_all[i*NB +: NB] = op;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clock);
            if (ack[i]) ok = 1'b1;
        end
        t_ack = cyc - t0;
        chk("ack_wait", ok, 1'b1);
        @(posedge clock); #1;
        req[i] = 1'b0; got_ack[i] = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clock);
            if (done[i]) begin ok = 1'b1; res = sqrt_out; end
        end
        t_done = cyc - t0;
        chk("done_wait", ok, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    logic [HW-1:0] res;
    int ta, td, t0, a0, n;
    logic [NB-1:0] bop [5] = '{32'd0, 32'd1, 32'd2, 32'hFFFF_FFFF, 32'h4000_0000};
    int            bexp[5] = '{0, 1, 1, 65535, 32768};
    int            fexp[4] = '{0, 3, 0, 3};

    initial begin
        // reset state
        @(negedge clock);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ack", ack, '0);
        chk("rst_xin", sq_xin, '0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        // idle: nothing moves for 50 cycles
        a0 = act;
        drive(50, '0, 1'b0);
        chk("idle_act", act - a0, 0);

        // all four at once: 0,1,2,3 with results 2..5, 20 cycles apart
        ack_g.delete(); ack_c.delete(); done_g.delete(); done_v.delete();
        @(posedge clock); #1;
        t0 = cyc;
        for (int i = 0; i < NR; i++) xin_all[i*NB +: NB] = NB'((i + 2) * (i + 2));
        req = '1;
        drive(90, '0, 1'b0);
        chk("all4_nack", ack_g.size(), 4);
        chk("all4_ndone", done_g.size(), 4);
        chk("all4_first", ack_c.size() > 0 ? ack_c[0] - t0 : -1, 1);
        n = (ack_g.size() < 4) ? ack_g.size() : 4;
        for (int k = 0; k < n; k++) begin
            chk("all4_order", ack_g[k], k);
            chk("all4_gap", ack_c[k] - ack_c[0], LAT * k);
        end
        n = (done_g.size() < 4) ? done_g.size() : 4;
        for (int k = 0; k < n; k++) begin
            chk("all4_dgnt", done_g[k], k);
            chk("all4_res", done_v[k], k + 2);
        end

        // fairness: 0 re-requests after every ack while 3 holds its request
        ack_g.delete(); ack_c.delete();
        @(posedge clock); #1;
        xin_all[0 +: NB] = 32'd81; xin_all[3*NB +: NB] = 32'd49;
        req[0] = 1'b1; req[3] = 1'b1;
        drive(85, 4'b1001, 1'b0);
        drive(70, '0, 1'b0);
        chk("fair_n", ack_g.size() >= 4, 1'b1);
        n = (ack_g.size() < 4) ? ack_g.size() : 4;
        for (int k = 0; k < n; k++) chk("fair_alt", ack_g[k], fexp[k]);

        // single requester, latency landmarks
        job(0, 32'd144, res, ta, td);
        chk("single_ack", ta, 1);
        chk("single_done", td, LAT);
        chk("single_res", res, 12);
        chk("single_start", start_c - (cyc - LAT), 1);
        chk("single_stop", stop_c - (cyc - LAT), HW + 2);
        @(negedge clock);
        chk("single_idle", busy, 1'b0);

        // boundary operands on requester 2
        for (int k = 0; k < 5; k++) begin
            job(2, bop[k], res, ta, td);
            chk("bnd_res", res, bexp[k]);
        end

        // reset mid-RUN aborts the job
        @(posedge clock); #1;
        t0 = cyc; req[1] = 1'b1; xin_all[1*NB +: NB] = 32'd12345;
        drive(7, '0, 1'b0);
        @(posedge clock); #2;
        reset = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_ack", ack, '0);
        chk("arst_done", done, '0);
        chk("arst_sq", {sq_start, sq_stop}, 2'b00);
        chk("arst_xin", sq_xin, '0);
        chk("arst_out", sqrt_out, '0);
        n = done_g.size();
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        drive(25, '0, 1'b0);
        chk("arst_nodone", done_g.size() - n, 0);
        job(1, 32'd100, res, ta, td);
        chk("arst_res", res, 10);
        chk("arst_lat", td, LAT);

        // randomized traffic against the reference
        n = done_g.size();
        drive(1500, '0, 1'b1);
        drive(120, '0, 1'b0);
        chk("rnd_jobs", done_g.size() - n > 20, 1'b1);
        chk("rnd_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
